// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request controller.
// Holds the FSM encoding, the default sizing constants and the priority encoder.
package irq_pkg;

    localparam int DEF_NUM_SRC = 8;
    localparam int DEF_SRC_W   = 3;
    localparam int PRIO_MAX    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Lowest set index wins; scanning downwards lets the lowest hit overwrite the others.
    function automatic logic [4:0] prio_enc(input logic [PRIO_MAX-1:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = PRIO_MAX - 1; i >= 0; i--) begin
            idx = vec[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single request line: two-flop synchroniser plus history flop.
// Produces a one-cycle rise pulse.
module irq_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic src_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchroniser chain. The history flop clears on reset, so a line already high counts as one rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= src_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/irq_controller.sv
// Multi-source interrupt controller: pending/mask bookkeeping, priority selection and
// the REQ/ack/eoi handshake with the processor's interrupt unit.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int SRC_W   = DEF_SRC_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               ack,
    input  logic               eoi,
    output logic               IRQ,
    output logic [SRC_W-1:0]   cause,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] req_vec_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] mask_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [SRC_W-1:0]   prio_s;
    logic [SRC_W-1:0]   cause_d;
    logic [SRC_W-1:0]   cause_q;
    irq_state_e         state_d;
    irq_state_e         state_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_sync_edge u_sync_edge (
            .clock   (clock),
            .reset_n (reset_n),
            .src_i   (src_in[g]),
            .rise_o  (rise_s[g])
        );
    end

    assign req_vec_s = pending_q & mask_q;
    assign prio_s    = SRC_W'(prio_enc(PRIO_MAX'(req_vec_s)));

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, cause tracking and the pending clear issued by ack.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        clr_s   = {NUM_SRC{1'b0}};
        case (state_q)
            IDLE: begin
                if (req_vec_s != {NUM_SRC{1'b0}}) begin
                    state_d = REQ;
                    cause_d = prio_s;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // ack acts on the cause already presented, so a late pre-emption cannot redirect it.
                if (ack) begin
                    state_d        = SERVICE;
                    clr_s[cause_q] = 1'b1;
                end else if (req_vec_s == {NUM_SRC{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    cause_d = prio_s;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fresh rise beats a same-cycle clear so the new event is not lost.
    always_comb begin
        pending_d = (pending_q & ~clr_s) | rise_s;
        if (mask_we) begin
            mask_d = mask_wdata;
        end else begin
            mask_d = mask_q;
        end
    end

    // Pending, mask and cause registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= {NUM_SRC{1'b0}};
            mask_q    <= {NUM_SRC{1'b0}};
            cause_q   <= {SRC_W{1'b0}};
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cause_q   <= cause_d;
        end
    end

    // Outputs decode straight from registers.
    always_comb begin
        IRQ        = (state_q == REQ);
        in_service = (state_q == SERVICE);
        cause      = cause_q;
        pending    = pending_q;
        mask       = mask_q;
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed table, hand sequences and a
// randomized run against a behavioural model.
module tb_irq_controller;

    logic       clock;
    logic       reset_n;
    logic [7:0] src_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] cause;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] mask;

    int checks = 0;
    int errors = 0;

    irq_controller dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .src_in     (src_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .eoi        (eoi),
        .IRQ        (irq),
        .cause      (cause),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: mode 0 = idle, 1 = requesting, 2 = servicing.
    int         m_mode;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [2:0] m_cause;
    logic [7:0] m_hist[$];

    typedef struct {
        logic [7:0] src;
        logic       we;
        logic [7:0] wd;
        logic       a;
        logic       e;
        logic       x_irq;
        logic [2:0] x_cause;
        logic       x_svc;
        logic [7:0] x_pend;
        logic [7:0] x_mask;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pend  = 8'h00;
        m_mask  = 8'h00;
        m_cause = 3'd0;
        m_hist.delete();
    endtask

    // One clock edge of the model; a rise seen at edge n is a line sampled high at n-2 and low at n-3.
    task automatic model_edge();
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] ev;
        logic [7:0] req;
        logic [7:0] clr;
        s2  = (m_hist.size() > 1) ? m_hist[1] : 8'h00;
        s3  = (m_hist.size() > 2) ? m_hist[2] : 8'h00;
        ev  = s2 & ~s3;
        req = m_pend & m_mask;
        clr = 8'h00;
        if (m_mode == 0) begin
            if (req != 8'h00) begin
                m_mode  = 1;
                m_cause = 3'(lowest(req));
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                clr[m_cause] = 1'b1;
                m_mode = 2;
            end else if (req == 8'h00) begin
                m_mode = 0;
            end else begin
                m_cause = 3'(lowest(req));
            end
        end else begin
            if (eoi) m_mode = 0;
        end
        m_pend = (m_pend & ~clr) | ev;
        if (mask_we) m_mask = mask_wdata;
        m_hist.push_front(src_in);
        if (m_hist.size() > 3) void'(m_hist.pop_back());
    endtask

    task automatic compare_model(input string tag);
        check({tag, " model irq"},        irq,        (m_mode == 1) ? 1'b1 : 1'b0);
        check({tag, " model cause"},      cause,      m_cause);
        check({tag, " model in_service"}, in_service, (m_mode == 2) ? 1'b1 : 1'b0);
        check({tag, " model pending"},    pending,    m_pend);
        check({tag, " model mask"},       mask,       m_mask);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic cyc(input logic [7:0] s, input logic we, input logic [7:0] wd,
                       input logic a, input logic e, input string tag);
        src_in     = s;
        mask_we    = we;
        mask_wdata = wd;
        ack        = a;
        eoi        = e;
        step(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [7:0] flip;

        // Directed vectors: src, we, wdata, ack, eoi | irq, cause, in_service, pending, mask
        tbl.push_back('{8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h04});
        tbl.push_back('{8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 8'h04});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'h04});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h08, 8'h00});
        tbl.push_back('{8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h08, 8'h08});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 8'h08});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'h08});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 8'h08});

        reset_n = 1'b0;
        src_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset irq", irq, 1'b0);
        check("reset in_service", in_service, 1'b0);
        check("reset pending", pending, 8'h00);
        check("reset mask", mask, 8'h00);
        check("reset cause", cause, 3'd0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].src, tbl[i].we, tbl[i].wd, tbl[i].a, tbl[i].e, $sformatf("row%0d", i));
            check($sformatf("row%0d irq", i),        irq,        tbl[i].x_irq);
            check($sformatf("row%0d cause", i),      cause,      tbl[i].x_cause);
            check($sformatf("row%0d in_service", i), in_service, tbl[i].x_svc);
            check($sformatf("row%0d pending", i),    pending,    tbl[i].x_pend);
            check($sformatf("row%0d mask", i),       mask,       tbl[i].x_mask);
        end

        // Simultaneous rises on 5 and 1: 1 served first, 5 follows one cycle after returning to idle.
        cyc(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, "prio");
        cyc(8'h22, 1'b0, 8'h00, 1'b0, 1'b0, "prio");
        idle_cycles(3, "prio");
        check("prio irq", irq, 1'b1);
        check("prio cause", cause, 3'd1);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "prio ack");
        check("prio ack pending", pending, 8'h20);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "prio eoi");
        check("prio eoi irq", irq, 1'b0);
        idle_cycles(1, "prio next");
        check("prio next irq", irq, 1'b1);
        check("prio next cause", cause, 3'd5);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "prio ack2");
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "prio eoi2");

        // Mask removes the only request while in REQ; a stray ack in idle is ignored.
        cyc(8'h00, 1'b1, 8'h10, 1'b0, 1'b0, "unmask");
        cyc(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, "unmask");
        idle_cycles(3, "unmask");
        check("unmask irq", irq, 1'b1);
        check("unmask cause", cause, 3'd4);
        cyc(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "unmask wr");
        check("unmask wr irq", irq, 1'b1);
        idle_cycles(1, "unmask drop");
        check("unmask drop irq", irq, 1'b0);
        check("unmask drop pending", pending, 8'h10);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "idle ack");
        check("idle ack pending", pending, 8'h10);
        check("idle ack in_service", in_service, 1'b0);

        // Pre-emption: source 0 arrives while 6 is requested, ack then clears 0 only.
        cyc(8'h00, 1'b1, 8'h41, 1'b0, 1'b0, "preempt");
        cyc(8'h40, 1'b0, 8'h00, 1'b0, 1'b0, "preempt");
        idle_cycles(3, "preempt");
        check("preempt first cause", cause, 3'd6);
        cyc(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, "preempt");
        idle_cycles(3, "preempt");
        check("preempt irq", irq, 1'b1);
        check("preempt cause", cause, 3'd0);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "preempt ack");
        check("preempt ack pending", pending, 8'h50);
        cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, "preempt eoi");
        idle_cycles(1, "preempt next");
        check("preempt next cause", cause, 3'd6);
        cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "preempt ack2");
        check("svc in_service", in_service, 1'b1);

        // Reset during SERVICE with source 7 held high across release.
        src_in  = 8'h80;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst irq", irq, 1'b0);
        check("rst in_service", in_service, 1'b0);
        check("rst pending", pending, 8'h00);
        check("rst mask", mask, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, "held");
        check("held pending", pending, 8'h80);
        for (int i = 0; i < 3; i++) cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, "held");
        check("held once pending", pending, 8'h80);
        check("held irq", irq, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(7) == 0);
            src_in     = src_in ^ flip;
            mask_we    = ($urandom_range(15) == 0);
            mask_wdata = 8'($urandom);
            ack        = ($urandom_range(3) == 0);
            eoi        = ($urandom_range(3) == 0);
            step("rand");
            if ($urandom_range(599) == 0) begin
                #3;
                reset_n = 1'b0;
                model_reset();
                #1;
                compare_model("rand rst");
                @(posedge clock);
                #1;
                reset_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
